mc_ctrl_seq: RTL

Multicycle control sequencer for the simplified 16-bit RISC-V processor. It drives the `clk_en` inputs of the datapath's enable registers (IR, PC, A/B, ALUOut, MDR) and the register-file write strobe. It sequences FETCH/DECODE/EXEC/MEM/WB per instruction, handles variable-latency memory with a ready handshake, and halts on HALT, illegal opcode, or memory timeout.

---
 rtl/mc_ctrl_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_seq.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with ready handshake,
// memory watchdog and sticky halt/illegal/bus-error status.
module mc_ctrl_seq #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       ir_en,
    output logic       pc_en,
    output logic       ab_en,
    output logic       aluout_en,
    output logic       mdr_en,
    output logic       rf_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_R     = 4'b0000;
    localparam logic [3:0] OP_I     = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_JAL   = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    logic [2:0] state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       halted_q, halted_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;

    logic ir_c, pc_c, ab_c, ao_c, mdr_c, rf_c, mwe_c;
    logic mem_phase, timeout, op_legal;

    assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timeout   = mem_phase && !mem_ready && (WAIT_MAX != 8'd0)
                       && (wcnt_q == WAIT_MAX);
    assign op_legal  = (opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE,
                                       OP_BEQ, OP_JAL, OP_HALT});

    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        ir_c      = 1'b0;
        pc_c      = 1'b0;
        ab_c      = 1'b0;
        ao_c      = 1'b0;
        mdr_c     = 1'b0;
        rf_c      = 1'b0;
        mwe_c     = 1'b0;
        mem_req   = 1'b0;
        iord      = 1'b0;
        alu_srca  = 1'b0;
        alu_srcb  = 2'b00;
        alu_op    = 2'b00;
        pc_src    = 2'b00;
        wb_sel    = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_c     = 1'b1;
                    pc_c     = 1'b1;
                    alu_srcb = 2'b01;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                // branch target is precomputed into ALUOut here
                ab_c     = 1'b1;
                ao_c     = 1'b1;
                alu_srcb = 2'b10;
                if (opcode == OP_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (!op_legal) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (opcode)
                    OP_R, OP_I: begin
                        alu_srca = 1'b1;
                        alu_srcb = (opcode == OP_I) ? 2'b10 : 2'b00;
                        alu_op   = 2'b10;
                        ao_c     = 1'b1;
                        state_d  = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_srca = 1'b1;
                        alu_srcb = 2'b10;
                        ao_c     = 1'b1;
                        state_d  = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_srca = 1'b1;
                        alu_op   = 2'b01;
                        pc_src   = 2'b01;
                        pc_c     = zero;
                        state_d  = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_c    = 1'b1;
                        pc_src  = 2'b10;
                        rf_c    = 1'b1;
                        wb_sel  = 2'b10;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mwe_c   = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_c   = 1'b1;
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            S_WB: begin
                rf_c    = 1'b1;
                wb_sel  = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            wcnt_d = 8'd0;
        end else if (mem_phase && !mem_ready) begin
            wcnt_d = wcnt_q + 8'd1;
        end else begin
            wcnt_d = wcnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wcnt_q    <= 8'd0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // reset aborts the instruction: no enable may leak out while it is held
    assign ir_en     = ir_c  & ~rst;
    assign pc_en     = pc_c  & ~rst;
    assign ab_en     = ab_c  & ~rst;
    assign aluout_en = ao_c  & ~rst;
    assign mdr_en    = mdr_c & ~rst;
    assign rf_we     = rf_c  & ~rst;
    assign mem_we    = mwe_c & ~rst;

    assign state   = state_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule
